// File: rtl/dmem_responder_if.sv
// Bus bundle between the processor/consumer side and the data-memory responder.
// Carries the processor's word read/write port and the TX FIFO drain port.
interface dmem_responder_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address_dmem;
    logic [DATA_WIDTH-1:0] data;
    logic                  wren;
    logic [DATA_WIDTH-1:0] q_dmem;
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_ready;
    logic                  overflow;

    // Processor plus TX consumer: drives address/data/wren and tx_ready.
    modport master (
        output address_dmem,
        output data,
        output wren,
        output tx_ready,
        input  q_dmem,
        input  tx_valid,
        input  tx_data,
        input  overflow
    );

    // Responder: returns read data and presents the TX FIFO head.
    modport slave (
        input  address_dmem,
        input  data,
        input  wren,
        input  tx_ready,
        output q_dmem,
        output tx_valid,
        output tx_data,
        output overflow
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM below MMIO_BASE plus a 16-word MMIO window
// (cycle counter, TX FIFO push port, status, scratch). Every cycle performs a
// read whose result appears on q_dmem one cycle later; RAM is read-first.
module dmem_responder #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 12'hFF0,
    parameter int                    FIFO_DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int RAM_WORDS = int'(MMIO_BASE);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    localparam logic [3:0]            OFF_CYCLE   = 4'd0;
    localparam logic [3:0]            OFF_TX      = 4'd1;
    localparam logic [3:0]            OFF_STATUS  = 4'd2;
    localparam logic [3:0]            OFF_SCRATCH = 4'd3;
    localparam logic [CNT_W-1:0]      CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]      PTR_ZERO    = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]      PTR_ONE     = PTR_W'(1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ONE    = DATA_WIDTH'(1);

    // Storage
    logic [DATA_WIDTH-1:0] r_mem  [0:RAM_WORDS-1];
    logic [DATA_WIDTH-1:0] r_fifo [0:FIFO_DEPTH-1];

    // Registers
    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] r_cycle;
    logic [DATA_WIDTH-1:0] r_scratch;
    logic                  r_overflow;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    // Decode and control wires
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [3:0]            w_reg_sel;
    logic                  w_is_ram;
    logic                  w_is_mmio;
    logic                  w_wr_ram;
    logic                  w_wr_cycle;
    logic                  w_wr_tx;
    logic                  w_wr_status;
    logic                  w_wr_scratch;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_mmio_rd;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Address decode. The window is the 16 words starting at MMIO_BASE.
    assign w_offset  = bus.address_dmem - MMIO_BASE;
    assign w_reg_sel = w_offset[3:0];
    assign w_is_ram  = (bus.address_dmem < MMIO_BASE);
    assign w_is_mmio = !w_is_ram && (w_offset[ADDR_WIDTH-1:4] == '0);

    // Write strobes; a reset cycle suppresses every write.
    assign w_wr_ram     = !reset && bus.wren && w_is_ram;
    assign w_wr_cycle   = !reset && bus.wren && w_is_mmio && (w_reg_sel == OFF_CYCLE);
    assign w_wr_tx      = !reset && bus.wren && w_is_mmio && (w_reg_sel == OFF_TX);
    assign w_wr_status  = !reset && bus.wren && w_is_mmio && (w_reg_sel == OFF_STATUS);
    assign w_wr_scratch = !reset && bus.wren && w_is_mmio && (w_reg_sel == OFF_SCRATCH);

    // FIFO flags. A same-cycle pop frees the slot a full-FIFO push needs.
    assign w_empty = (r_count == CNT_ZERO);
    assign w_full  = (r_count == CNT_FULL);
    assign w_pop   = !reset && !w_empty && bus.tx_ready;
    assign w_push  = w_wr_tx && (!w_full || w_pop);
    assign w_drop  = w_wr_tx && w_full && !w_pop;

    assign bus.tx_valid = !w_empty;
    assign bus.tx_data  = r_fifo[r_rd_ptr];
    assign bus.overflow = r_overflow;
    assign bus.q_dmem   = r_q;

    // Assemble the STATUS word from pre-edge FIFO state.
    always_comb begin
        w_status      = DATA_ZERO;
        w_status[3:0] = 4'(r_count);
        w_status[4]   = w_empty;
        w_status[5]   = w_full;
        w_status[6]   = r_overflow;
    end

    // MMIO read mux; unmapped window offsets read as zero.
    always_comb begin
        w_mmio_rd = DATA_ZERO;
        case (w_reg_sel)
            OFF_CYCLE:   w_mmio_rd = r_cycle;
            OFF_TX:      w_mmio_rd = DATA_ZERO;
            OFF_STATUS:  w_mmio_rd = w_status;
            OFF_SCRATCH: w_mmio_rd = r_scratch;
            default:     w_mmio_rd = DATA_ZERO;
        endcase
    end

    // Select RAM or MMIO read data for the current address.
    always_comb begin
        w_rd_data = DATA_ZERO;
        if (w_is_ram) begin
            w_rd_data = r_mem[bus.address_dmem];
        end else if (w_is_mmio) begin
            w_rd_data = w_mmio_rd;
        end else begin
            w_rd_data = DATA_ZERO;
        end
    end

    // Registered read port: fixed one-cycle latency, read-first with writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= DATA_ZERO;
        end else begin
            r_q <= w_rd_data;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (w_wr_ram) begin
            r_mem[bus.address_dmem] <= bus.data;
        end
    end

    // Free-running cycle counter, loadable by a CYCLE write.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle <= DATA_ZERO;
        end else if (w_wr_cycle) begin
            r_cycle <= bus.data;
        end else begin
            r_cycle <= r_cycle + DATA_ONE;
        end
    end

    // Scratch register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scratch <= DATA_ZERO;
        end else if (w_wr_scratch) begin
            r_scratch <= bus.data;
        end
    end

    // Sticky overflow: a drop in the same cycle as a W1C clear keeps it set.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_wr_status && bus.data[6]) begin
            r_overflow <= 1'b0;
        end
    end

    // FIFO entry storage; cleared on reset so tx_data is never unknown.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= DATA_ZERO;
            end
        end else if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM read-first, cycle counter load/wrap,
// TX FIFO fill/overflow/full-with-pop/drain, mid-traffic reset, unmapped MMIO.
module tb_dmem_responder;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    dmem_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

    dmem_responder #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (32),
        .MMIO_BASE  (12'hFF0),
        .FIFO_DEPTH (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one processor cycle, then sample 1 time unit after the edge.
    task automatic cyc(input logic we, input logic [11:0] a, input logic [31:0] d);
        bus.wren         = we;
        bus.address_dmem = a;
        bus.data         = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] exp_head;
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        bus.wren         = 1'b0;
        bus.address_dmem = 12'h000;
        bus.data         = 32'h0;
        bus.tx_ready     = 1'b0;

        // Two reset cycles, then release.
        cyc(1'b0, 12'h000, 32'h0);
        cyc(1'b0, 12'h000, 32'h0);
        reset = 1'b0;
        check("rst_q", bus.q_dmem, 32'h0);
        check("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        check("rst_overflow", {31'h0, bus.overflow}, 32'h0);

        // Counter: read in the 10th cycle after release returns 9.
        for (int i = 0; i < 9; i++) cyc(1'b0, 12'h000, 32'h0);
        cyc(1'b0, 12'hFF0, 32'h0);
        check("cycle_10th", bus.q_dmem, 32'd9);
        cyc(1'b1, 12'hFF0, 32'hFFFF_FFFE);
        check("cycle_rd_during_wr", bus.q_dmem, 32'd10);
        cyc(1'b0, 12'h000, 32'h0);
        cyc(1'b0, 12'hFF0, 32'h0);
        check("cycle_max", bus.q_dmem, 32'hFFFF_FFFF);
        cyc(1'b0, 12'hFF0, 32'h0);
        check("cycle_wrap", bus.q_dmem, 32'h0);

        // RAM write, readback, read-first collision.
        cyc(1'b1, 12'h005, 32'hDEAD_BEEF);
        cyc(1'b0, 12'h005, 32'h0);
        check("ram_rd", bus.q_dmem, 32'hDEAD_BEEF);
        cyc(1'b1, 12'h005, 32'h1);
        check("ram_read_first", bus.q_dmem, 32'hDEAD_BEEF);
        cyc(1'b0, 12'h005, 32'h0);
        check("ram_new", bus.q_dmem, 32'h1);

        // Fill FIFO with 1..8, no consumer.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 12'hFF1, 32'(i));
        check("tx_rd_zero", bus.q_dmem, 32'h0);
        check("fill_valid", {31'h0, bus.tx_valid}, 32'h1);
        check("fill_head", bus.tx_data, 32'h1);
        cyc(1'b0, 12'hFF2, 32'h0);
        check("status_full", bus.q_dmem, 32'h28);
        cyc(1'b1, 12'hFF1, 32'h9);
        check("ovf_set", {31'h0, bus.overflow}, 32'h1);
        cyc(1'b0, 12'hFF2, 32'h0);
        check("status_ovf", bus.q_dmem, 32'h68);
        cyc(1'b1, 12'hFF2, 32'h40);
        check("status_rd_on_clr", bus.q_dmem, 32'h68);
        check("ovf_clr", {31'h0, bus.overflow}, 32'h0);
        cyc(1'b0, 12'hFF2, 32'h0);
        check("status_after_clr", bus.q_dmem, 32'h28);

        // Full FIFO: pop and push in the same cycle.
        bus.tx_ready = 1'b1;
        cyc(1'b1, 12'hFF1, 32'hA5);
        bus.tx_ready = 1'b0;
        check("pp_head", bus.tx_data, 32'h2);
        check("pp_ovf", {31'h0, bus.overflow}, 32'h0);
        cyc(1'b0, 12'hFF2, 32'h0);
        check("pp_status", bus.q_dmem, 32'h28);

        // Drain: 2..8 then A5.
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_head = (i < 7) ? 32'(i + 2) : 32'hA5;
            check("drain_head", bus.tx_data, exp_head);
            cyc(1'b0, 12'h000, 32'h0);
        end
        bus.tx_ready = 1'b0;
        check("drain_valid", {31'h0, bus.tx_valid}, 32'h0);
        cyc(1'b0, 12'hFF2, 32'h0);
        check("status_empty", bus.q_dmem, 32'h10);

        // Reset during traffic.
        cyc(1'b1, 12'hFF3, 32'hCAFE_F00D);
        cyc(1'b0, 12'hFF3, 32'h0);
        check("scratch_rd", bus.q_dmem, 32'hCAFE_F00D);
        cyc(1'b1, 12'hFF1, 32'h11);
        cyc(1'b1, 12'hFF1, 32'h12);
        cyc(1'b1, 12'hFF1, 32'h13);
        check("pre_rst_valid", {31'h0, bus.tx_valid}, 32'h1);
        reset = 1'b1;
        cyc(1'b1, 12'hFF1, 32'h77);
        reset = 1'b0;
        check("mid_rst_valid", {31'h0, bus.tx_valid}, 32'h0);
        check("mid_rst_q", bus.q_dmem, 32'h0);
        check("mid_rst_ovf", {31'h0, bus.overflow}, 32'h0);
        cyc(1'b0, 12'hFF0, 32'h0);
        check("mid_rst_cycle", bus.q_dmem, 32'h0);
        cyc(1'b0, 12'hFF2, 32'h0);
        check("mid_rst_status", bus.q_dmem, 32'h10);
        cyc(1'b0, 12'hFF3, 32'h0);
        check("mid_rst_scratch", bus.q_dmem, 32'h0);
        cyc(1'b0, 12'h005, 32'h0);
        check("mid_rst_ram", bus.q_dmem, 32'h1);

        // Unmapped window offsets.
        cyc(1'b1, 12'hFF3, 32'h0000_55AA);
        cyc(1'b1, 12'hFF7, 32'h1234_5678);
        cyc(1'b0, 12'hFF7, 32'h0);
        check("unmapped_rd", bus.q_dmem, 32'h0);
        cyc(1'b0, 12'hFF3, 32'h0);
        check("unmapped_scratch", bus.q_dmem, 32'h0000_55AA);
        cyc(1'b0, 12'hFFF, 32'h0);
        check("unmapped_top", bus.q_dmem, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
